// File: rtl/bsg_hash_bank_reverse_pkg.sv
// Shared types for the bank-hash reverse sequencer: FSM state encoding and the step counter width.
package bsg_hash_bank_reverse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // banks_p <= 16 means at most 5 shift-add steps, which fits in 3 bits
    localparam int step_width_gp = 3;

endpackage

// File: rtl/bsg_hash_bank_reverse_seq.sv
// Rebuilds an address from {bank, index} as index*banks_p + bank with a serial shift-add.
// Define BSG_HASH_BANK_REVERSE_CHECK_EN to flag (and zero) results whose bank is out of range.
//
// state | meaning
// IDLE  | ready for a request; ready_o=1
// CALC  | one shift-add step per cycle over the bits of banks_p
// DONE  | result held on o/error_o with v_o=1 until yumi_i
module bsg_hash_bank_reverse_seq
    import bsg_hash_bank_reverse_pkg::*;
#(
    parameter int banks_p = 1,
    parameter int width_p = 16,
    localparam int lg_banks_lp    = (banks_p > 1) ? $clog2(banks_p) : 1,
    localparam int index_width_lp = width_p - $clog2(banks_p),
    localparam int nb_lp          = $clog2(banks_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [lg_banks_lp-1:0]    bank_i,
    input  logic [index_width_lp-1:0] index_i,
    output logic                      ready_o,
    output logic                      v_o,
    output logic [width_p-1:0]        o,
    output logic                      error_o,
    input  logic                      yumi_i
);

    localparam logic [7:0]               banks_bits_lp = 8'(banks_p);
    localparam logic [step_width_gp-1:0] last_step_lp  = step_width_gp'(nb_lp - 1);

    state_e                   state_r, state_n;
    logic [width_p-1:0]       acc_r, acc_n;
    logic [width_p-1:0]       idx_r, idx_n;
    logic [step_width_gp-1:0] k_r, k_n;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            acc_r   <= '0;
            idx_r   <= '0;
            k_r     <= '0;
        end else begin
            state_r <= state_n;
            acc_r   <= acc_n;
            idx_r   <= idx_n;
            k_r     <= k_n;
        end
    end

    always_comb begin
        state_n = state_r;
        acc_n   = acc_r;
        idx_n   = idx_r;
        k_n     = k_r;
        case (state_r)
            IDLE: begin
                if (v_i) begin
                    idx_n   = width_p'(index_i);
                    acc_n   = width_p'(bank_i);
                    k_n     = '0;
                    state_n = CALC;
                end
            end
            CALC: begin
                // carries past width_p fall off, matching the truncated address space
                if (banks_bits_lp[k_r]) begin
                    acc_n = acc_r + (idx_r << k_r);
                end
                k_n = k_r + 1'b1;
                if (k_r == last_step_lp) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (yumi_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ready_o = (state_r == IDLE) & reset_n_i;
    assign v_o     = (state_r == DONE);

`ifdef BSG_HASH_BANK_REVERSE_CHECK_EN
    localparam logic [lg_banks_lp:0] banks_cmp_lp = (lg_banks_lp + 1)'(banks_p);

    logic err_r;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            err_r <= 1'b0;
        end else if (state_r == IDLE && v_i) begin
            err_r <= ({1'b0, bank_i} >= banks_cmp_lp);
        end
    end

    assign error_o = err_r;
    assign o       = err_r ? '0 : acc_r;
`else
    assign error_o = 1'b0;
    assign o       = acc_r;
`endif

endmodule

// File: tb/tb_bsg_hash_bank_reverse_seq.sv
// Directed bench: three instances (banks_p = 3, 1, 4) exercised with hand-computed vectors.
module tb_bsg_hash_bank_reverse_seq;

    logic clk_i = 1'b0;
    logic reset_n_i;

    logic [2:0]       v, yumi, rdy, vo, err;
    logic [2:0][1:0]  bnk;
    logic [2:0][15:0] idx;
    logic [2:0][15:0] o_t;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    // u=0: banks_p=3 (nb_lp=2), u=1: banks_p=1 (nb_lp=1), u=2: banks_p=4 (nb_lp=3)
    bsg_hash_bank_reverse_seq #(.banks_p(3), .width_p(16)) u_b3 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v[0]), .bank_i(bnk[0][1:0]),
        .index_i(idx[0][13:0]), .ready_o(rdy[0]), .v_o(vo[0]), .o(o_t[0]),
        .error_o(err[0]), .yumi_i(yumi[0]));

    bsg_hash_bank_reverse_seq #(.banks_p(1), .width_p(16)) u_b1 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v[1]), .bank_i(bnk[1][0:0]),
        .index_i(idx[1][15:0]), .ready_o(rdy[1]), .v_o(vo[1]), .o(o_t[1]),
        .error_o(err[1]), .yumi_i(yumi[1]));

    bsg_hash_bank_reverse_seq #(.banks_p(4), .width_p(16)) u_b4 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v[2]), .bank_i(bnk[2][1:0]),
        .index_i(idx[2][13:0]), .ready_o(rdy[2]), .v_o(vo[2]), .o(o_t[2]),
        .error_o(err[2]), .yumi_i(yumi[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one-cycle request; returns in the first cycle after the handshake edge
    task automatic req(input int u, input logic [1:0] b, input logic [15:0] ix);
        v[u]   = 1'b1;
        bnk[u] = b;
        idx[u] = ix;
        chk("ready_before_req", 32'(rdy[u]), 32'd1);
        @(posedge clk_i); #1;
        v[u] = 1'b0;
    endtask

    // lat counts cycles from the handshake cycle t; v_o must first appear at t+nb_lp+1
    task automatic wait_v(input int u, input int exp_lat, input string tag);
        int lat = 1;
        while (!vo[u] && lat < 20) begin
            @(posedge clk_i); #1;
            lat++;
        end
        chk(tag, 32'(lat), 32'(exp_lat));
    endtask

    task automatic consume(input int u);
        yumi[u] = 1'b1;
        @(posedge clk_i); #1;
        yumi[u] = 1'b0;
        chk("ready_after_yumi", 32'(rdy[u]), 32'd1);
        chk("v_after_yumi", 32'(vo[u]), 32'd0);
    endtask

    initial begin
        logic seen;
        reset_n_i = 1'b0;
        v = '0; yumi = '0; bnk = '0; idx = '0;

        repeat (3) @(posedge clk_i);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk("rst_ready", 32'(rdy[u]), 32'd0);
            chk("rst_v", 32'(vo[u]), 32'd0);
            chk("rst_o", 32'(o_t[u]), 32'd0);
            chk("rst_err", 32'(err[u]), 32'd0);
        end
        reset_n_i = 1'b1;
        #1;
        chk("ready_release", 32'(rdy[0]), 32'd1);

        // banks 3: 5*3+2 = 17
        req(0, 2'd2, 16'd5);
        wait_v(0, 3, "lat_b3");
        chk("o_b3", 32'(o_t[0]), 32'd17);
        chk("err_b3", 32'(err[0]), 32'd0);
        consume(0);

        // yumi with v_o low must not disturb IDLE
        yumi[0] = 1'b1;
        @(posedge clk_i); #1;
        yumi[0] = 1'b0;
        chk("yumi_idle_ready", 32'(rdy[0]), 32'd1);
        chk("yumi_idle_v", 32'(vo[0]), 32'd0);

        // banks 1: identity
        req(1, 2'd0, 16'hBEEF);
        wait_v(1, 2, "lat_b1");
        chk("o_b1", 32'(o_t[1]), 32'hBEEF);
        consume(1);

        // banks 4: 0x3FFF*4+3, then v_i held high while result is held
        v[2] = 1'b1; bnk[2] = 2'd3; idx[2] = 16'h3FFF;
        chk("ready_b4", 32'(rdy[2]), 32'd1);
        @(posedge clk_i); #1;
        bnk[2] = 2'd2; idx[2] = 16'h0001;
        wait_v(2, 4, "lat_b4");
        chk("o_b4", 32'(o_t[2]), 32'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            chk("hold_o_b4", 32'(o_t[2]), 32'hFFFF);
            chk("hold_v_b4", 32'(vo[2]), 32'd1);
            chk("hold_ready_b4", 32'(rdy[2]), 32'd0);
        end
        yumi[2] = 1'b1;
        @(posedge clk_i); #1;
        yumi[2] = 1'b0;
        chk("ready_idle_b4", 32'(rdy[2]), 32'd1);
        @(posedge clk_i); #1;
        v[2] = 1'b0;
        wait_v(2, 4, "lat_b4_second");
        chk("o_b4_second", 32'(o_t[2]), 32'd6);
        consume(2);

        // banks 3 with out-of-range bank 3, index 7
        req(0, 2'd3, 16'd7);
        wait_v(0, 3, "lat_oor");
`ifdef BSG_HASH_BANK_REVERSE_CHECK_EN
        chk("o_oor", 32'(o_t[0]), 32'd0);
        chk("err_oor", 32'(err[0]), 32'd1);
`else
        chk("o_oor", 32'(o_t[0]), 32'd24);
        chk("err_oor", 32'(err[0]), 32'd0);
`endif
        consume(0);

        // reset during CALC discards the request
        req(0, 2'd2, 16'd5);
        chk("calc_v_low", 32'(vo[0]), 32'd0);
        chk("calc_ready_low", 32'(rdy[0]), 32'd0);
        reset_n_i = 1'b0;
        @(posedge clk_i); #1;
        chk("ready_in_reset", 32'(rdy[0]), 32'd0);
        reset_n_i = 1'b1;
        #1;
        chk("ready_after_reset", 32'(rdy[0]), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk_i); #1;
            seen = seen | vo[0];
        end
        chk("no_v_after_reset", 32'(seen), 32'd0);
        req(0, 2'd1, 16'd4);
        wait_v(0, 3, "lat_post_reset");
        chk("o_post_reset", 32'(o_t[0]), 32'd13);
        consume(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bsg_hash_bank_reverse_seq.md
BSG_HASH_BANK_REVERSE_SEQ -- requirements
Module: bsg_hash_bank_reverse_seq

Interface
REQ-001 SHALL have parameter banks_p, default 1, number of banks (1..16).
REQ-002 SHALL have parameter width_p, default 16, width of the original address.
REQ-003 SHALL define derived constants as follows:
- lg_banks_lp = max(1, $clog2(banks_p)).
- index_width_lp = width_p - $clog2(banks_p).
- nb_lp = $clog2(banks_p+1).
REQ-004 SHALL have port clk_i, input, 1, the single clock.
REQ-005 SHALL have port reset_n_i, input, 1, reset; it is synchronous and active-low.
REQ-006 SHALL have port v_i, input, 1, input request valid.
REQ-007 SHALL have port bank_i, input, lg_banks_lp, bank number.
REQ-008 SHALL have port index_i, input, index_width_lp, index within the bank.
REQ-009 SHALL have port ready_o, output, 1, input accepted when v_i & ready_o.
REQ-010 SHALL have port v_o, output, 1, result valid.
REQ-011 SHALL have port o, output, width_p, reconstructed address.
REQ-012 SHALL have port error_o, output, 1, bank out of range; qualified by v_o.
REQ-013 SHALL have port yumi_i, input, 1, consumer takes the result; legal only when v_o=1.

Function
REQ-014 SHALL compute o = (index_i * banks_p + bank_i) truncated to width_p, the inverse of the bank hash.
REQ-015 SHALL use a three-state FSM: IDLE, CALC, DONE.
REQ-016 SHALL drive ready_o=1 only in IDLE.
REQ-017 SHALL drive v_o=1 only in DONE.
REQ-018 SHALL, in IDLE on v_i & ready_o:
- capture index_i;
- load the accumulator with bank_i;
- set step k=0;
- go to CALC.
REQ-019 SHALL, in each CALC cycle:
- if banks_p bit k is 1, add (index << k) to the accumulator;
- increment k;
- leave CALC after nb_lp cycles and go to DONE.
REQ-020 SHALL, for a handshake at cycle t, assert v_o first in cycle t+nb_lp+1.
REQ-021 SHALL hold o, error_o and v_o stable in DONE until yumi_i; on yumi_i it SHALL go to IDLE, with ready_o=1 in the next cycle.
REQ-022 SHALL ignore v_i outside IDLE; no request is captured.
REQ-023 SHALL ignore yumi_i while v_o=0.
REQ-024 SHALL give minimum spacing between accepted requests of nb_lp+2 cycles.
REQ-025 SHALL truncate accumulator carry beyond width_p silently.

Reset
REQ-026 SHALL, on reset_n_i=0 at a clock edge, set the state to IDLE, the accumulator to 0, k to 0, v_o=0, o=0 and error_o=0.
REQ-027 SHALL, on reset during CALC or DONE, discard the in-flight result; no v_o follows.
REQ-028 SHALL drive ready_o=0 while reset_n_i=0 and ready_o=1 in the first cycle after release.

Configuration
REQ-029 SHALL support macro BSG_HASH_BANK_REVERSE_CHECK_EN with the following behaviour:
- when defined, a captured bank_i >= banks_p sets error_o=1 and forces o=0 for that result, with unchanged latency;
- when undefined, error_o SHALL be tied to 0 and an out-of-range bank_i is used arithmetically as-is.

Structure
REQ-030 SHALL place the FSM state typedef (IDLE/CALC/DONE) in the shared package bsg_hash_bank_reverse_pkg.
REQ-031 SHALL compute all derived widths as localparams in the module, not in the package.
REQ-032 SHALL have no sub-module; the shift-add datapath is inline.

Verification
REQ-033 SHALL cover: banks_p=3, width_p=16; bank_i=2, index_i=5 accepted at t -> v_o at t+3, o=17, error_o=0.
REQ-034 SHALL cover: banks_p=1; index_i=0xBEEF, bank_i=0 -> v_o at t+2, o=0xBEEF.
REQ-035 SHALL cover: banks_p=4; index_i=0x3FFF, bank_i=3 -> o=0xFFFF; then v_i held high with yumi_i delayed 5 cycles -> o stable and no second capture until IDLE.
REQ-036 SHALL cover: banks_p=3 with CHECK_EN defined; bank_i=3, index_i=7 -> v_o with error_o=1 and o=0; without the macro -> o=24, error_o=0.
REQ-037 SHALL cover: reset_n_i=0 for one cycle during CALC -> v_o never rises for that request, ready_o=1 next cycle, and a new request bank_i=1, index_i=4 (banks_p=3) -> o=13.
